store_sequencer: RTL

Multicycle controller that sequences partial and full-word stores through the store-merge datapath (store-size mux), memory and MDR. On a `start` request it checks alignment. Word stores are written directly. Byte and halfword stores run a read-modify-write:
- read the target word into MDR,
- merge via `ss_ctrl`,
- write it back.

It sits between the main control FSM and the memory/MDR/store-merge path, and owns `mem_rd`, `mem_wr`, `mdr_we` and `ss_ctrl` for the duration of a store.

---
 rtl/store_sequencer_if.sv | 25 ++
 rtl/store_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/store_sequencer_if.sv
// Request/response and memory-control bundle between the main control FSM,
// the store sequencer, and the memory/MDR/store-merge path.
interface store_sequencer_if;
  logic       start;
  logic [1:0] store_type;
  logic [1:0] addr_lo;
  logic       abort;
  logic       busy;
  logic       done;
  logic       error;
  logic       mem_rd;
  logic       mem_wr;
  logic       mdr_we;
  logic [1:0] ss_ctrl;

  modport master (
    output start, store_type, addr_lo, abort,
    input  busy, done, error, mem_rd, mem_wr, mdr_we, ss_ctrl
  );

  modport slave (
    input  start, store_type, addr_lo, abort,
    output busy, done, error, mem_rd, mem_wr, mdr_we, ss_ctrl
  );
endinterface

// File: rtl/store_sequencer.sv
// Multicycle store controller: direct word writes, read-modify-write for
// byte/halfword stores, alignment checking and abort before commit.
module store_sequencer #(
  parameter int unsigned MEM_LAT = 1
) (
  input logic           clk,
  input logic           reset,
  store_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT = (MEM_LAT > 0) ? CNT_W'(MEM_LAT - 1) : '0;

  localparam logic [1:0] ST_SW  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b10;
  localparam logic [1:0] ST_ILL = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    LATCH = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t           state;
  logic [1:0]       type_q;
  logic [CNT_W-1:0] wait_cnt;

  // Outputs are registered alongside the state, so each branch loads the
  // decode of the state it is moving into.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      type_q      <= 2'b00;
      wait_cnt    <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.error   <= 1'b0;
      bus.mem_rd  <= 1'b0;
      bus.mem_wr  <= 1'b0;
      bus.mdr_we  <= 1'b0;
      bus.ss_ctrl <= 2'b00;
    end else begin
      bus.busy    <= 1'b1;
      bus.done    <= 1'b0;
      bus.error   <= 1'b0;
      bus.mem_rd  <= 1'b0;
      bus.mem_wr  <= 1'b0;
      bus.mdr_we  <= 1'b0;
      bus.ss_ctrl <= 2'b00;

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            type_q <= bus.store_type;
            if ((bus.store_type == ST_ILL) ||
                (bus.store_type == ST_SW && bus.addr_lo != 2'b00) ||
                (bus.store_type == ST_SH && bus.addr_lo[0])) begin
              state     <= ERR;
              bus.error <= 1'b1;
            end else if (bus.store_type == ST_SW) begin
              state      <= WRITE;
              bus.mem_wr <= 1'b1;
            end else begin
              state      <= READ;
              bus.mem_rd <= 1'b1;
            end
          end else begin
            bus.busy <= 1'b0;
          end
        end

        READ: begin
          wait_cnt <= WAIT_INIT;
          if (bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (MEM_LAT > 0) begin
            state      <= WAIT;
            bus.mem_rd <= 1'b1;
          end else begin
            state       <= LATCH;
            bus.mdr_we  <= 1'b1;
            bus.ss_ctrl <= type_q;
          end
        end

        WAIT: begin
          if (bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (wait_cnt == '0) begin
            state       <= LATCH;
            bus.mdr_we  <= 1'b1;
            bus.ss_ctrl <= type_q;
          end else begin
            wait_cnt   <= wait_cnt - CNT_W'(1);
            bus.mem_rd <= 1'b1;
          end
        end

        LATCH: begin
          if (bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            state       <= WRITE;
            bus.mem_wr  <= 1'b1;
            bus.ss_ctrl <= type_q;
          end
        end

        WRITE: begin
          state    <= DONE;
          bus.done <= 1'b1;
        end

        DONE, ERR: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
